// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps the round datapath through load, Nr-1 full rounds and
// one final round, then holds the result until the consumer takes it.
module aes_round_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] key_len,
  input  logic       abort,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic       dp_final,
  output logic [3:0] round_idx,
  output logic [7:0] rcon,
  output logic       busy
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RCON_W = 8;
  localparam logic [RCON_W-1:0] RCON_INIT = RCON_W'(8'h01);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, HOLD} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  nr, nr_nxt, idx_nxt;
  logic [RCON_W-1:0] rcon_nxt;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] v);
    return {v[RCON_W-2:0], 1'b0} ^ (v[RCON_W-1] ? RCON_W'(8'h1B) : RCON_W'(8'h00));
  endfunction

  function automatic logic [IDX_W-1:0] nr_decode(input logic [1:0] kl);
    case (kl)
      2'b01:   return IDX_W'(12);
      2'b10:   return IDX_W'(14);
      default: return IDX_W'(10);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      nr        <= IDX_W'(10);
      round_idx <= '0;
      rcon      <= RCON_INIT;
    end else begin
      state     <= state_nxt;
      nr        <= nr_nxt;
      round_idx <= idx_nxt;
      rcon      <= rcon_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    nr_nxt      = nr;
    idx_nxt     = round_idx;
    rcon_nxt    = rcon;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_final    = 1'b0;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        in_ready = !abort;
        if (in_valid && !abort) begin
          nr_nxt    = nr_decode(key_len);
          idx_nxt   = '0;
          rcon_nxt  = RCON_INIT;
          state_nxt = INIT;
        end
      end
      INIT: begin
        dp_load   = 1'b1;
        idx_nxt   = IDX_W'(1);
        state_nxt = ROUND;
      end
      ROUND: begin
        dp_round_en = 1'b1;
        rcon_nxt    = xtime(rcon);
        idx_nxt     = IDX_W'(round_idx + IDX_W'(1));
        if (round_idx == IDX_W'(nr - IDX_W'(1)))
          state_nxt = FINAL;
      end
      FINAL: begin
        dp_round_en = 1'b1;
        dp_final    = 1'b1;
        rcon_nxt    = xtime(rcon);
        state_nxt   = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !abort;
        if (out_ready) begin
          idx_nxt  = '0;
          rcon_nxt = RCON_INIT;
          if (in_valid) begin
            nr_nxt    = nr_decode(key_len);
            state_nxt = INIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort cancels any in-flight or held block and wins over accept/out_ready.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      nr_nxt    = nr;
      idx_nxt   = '0;
      rcon_nxt  = RCON_INIT;
    end
  end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: a block and key are presented on the datapath inputs.
REQ-004 SHALL have port in_ready, output, 1 bit: the sequencer can accept a block this cycle.
REQ-005 SHALL have port key_len, input, 2 bits, sampled on accept: 00 selects Nr=10, 01 selects Nr=12, 10 selects Nr=14, and 11 is treated as 00.
REQ-006 SHALL have port abort, input, 1 bit: cancel the in-flight block.
REQ-007 SHALL have port out_valid, output, 1 bit: the datapath result is stable.
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-009 SHALL have port dp_load, output, 1 bit: datapath loads the state and applies the initial AddRoundKey.
REQ-010 SHALL have port dp_round_en, output, 1 bit: datapath executes one round this cycle.
REQ-011 SHALL have port dp_final, output, 1 bit: the current round skips MixColumns.
REQ-012 SHALL have port round_idx, output, 4 bits: index of the current round.
REQ-013 SHALL have port rcon, output, 8 bits: round constant for the key schedule.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, INIT, ROUND, FINAL and HOLD.
REQ-016 IDLE: in_ready = !abort, and accept = in_valid & in_ready latches Nr, loads rcon=0x01, and moves to INIT.
REQ-017 INIT lasts 1 cycle: dp_load=1, round_idx=0, rcon holds its value; next state ROUND.
REQ-018 ROUND lasts Nr-1 cycles: dp_round_en=1, dp_final=0, round_idx=1..Nr-1; the cycle with round_idx=Nr-1 moves to FINAL.
REQ-019 FINAL lasts 1 cycle: dp_round_en=1, dp_final=1, round_idx=Nr; next state HOLD.
REQ-020 rcon SHALL advance at the end of every ROUND and FINAL cycle via GF(2^8) xtime: next = {rcon[6:0],0} XOR (rcon[7] ? 0x1B : 0x00), so rcon = x^(round_idx-1) during round round_idx.
REQ-021 HOLD: out_valid=1; all dp_* outputs are 0; round_idx and rcon hold their values.
REQ-022 HOLD: out_valid SHALL stay high until out_ready=1.
REQ-023 HOLD: in_ready = out_ready & !abort.
REQ-024 HOLD: out_ready with in_valid accepts a new block and moves directly to INIT (back-to-back operation); out_ready without in_valid moves to IDLE.
REQ-025 Latency: an accept at cycle T gives out_valid first high at cycle T+Nr+2, which is 12, 14 or 16 cycles.
REQ-026 abort=1 in INIT, ROUND, FINAL or HOLD: next state IDLE, no out_valid pulse for that block, round_idx←0, rcon←0x01.
REQ-027 abort=1 in IDLE: no effect other than in_ready=0 for that cycle.
REQ-028 abort takes priority over a simultaneous accept or out_ready.
REQ-029 in_valid outside IDLE/HOLD SHALL be ignored, with in_ready=0.
REQ-030 key_len changes after the accept cycle SHALL have no effect on the block in flight.
REQ-031 round_idx SHALL never exceed 14 and never wraps.
REQ-032 At most one of dp_load, dp_round_en SHALL be high in any cycle.

Reset
REQ-033 rst=1 at a clock edge: state←IDLE, in_ready=1, out_valid=0, busy=0, dp_load=dp_round_en=dp_final=0, round_idx=0, rcon=0x01, Nr←10.
REQ-034 rst SHALL override abort, in_valid and out_ready.
REQ-035 rst asserted mid-operation SHALL discard the block with no out_valid pulse.

Verification
REQ-036 rst high 2 cycles then low -> in_ready=1, out_valid=0, busy=0, round_idx=0, rcon=0x01.
REQ-037 key_len=00, accept at cycle 0 -> dp_load at cycle 1; round_idx 1..9 at cycles 2..10 with rcon 01,02,04,08,10,20,40,80,1B; FINAL at cycle 11 with round_idx=10, rcon=0x36, dp_final=1; out_valid at cycle 12.
REQ-038 key_len=10, accept at cycle 0 -> FINAL at cycle 15 with round_idx=14, rcon=0x4D; out_valid at cycle 16.
REQ-039 out_ready held 0 for 3 cycles in HOLD, then out_ready=in_valid=1 -> out_valid held 3 cycles, new block accepted that same cycle, dp_load on the next cycle, no IDLE cycle in between.
REQ-040 abort at round_idx=5 -> IDLE next cycle, out_valid never asserts, in_ready=1, rcon=0x01.
REQ-041 rst pulse during ROUND at round_idx=7 -> all outputs at the REQ-033 values on the next cycle, no out_valid pulse.
